ula_seq: RTL and testbench

ULA_SEQ -- requirements
Module: ula_seq

---
 rtl/ula_pkg.sv | 21 ++
 rtl/ula_seq.sv | 117 +++++++++++
 tb/tb_ula_seq.sv | 217 +++++++++++++++++++++
 3 files changed

// File: rtl/ula_pkg.sv
// Shared types and constants for the sequenced ALU front end.
// Holds the FSM state encoding, the default widths and the ALU select codes.
package ula_pkg;

  localparam int W  = 5;
  localparam int SW = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  localparam logic [3:0] ALU_ADD   = 4'b0000;
  localparam logic [3:0] ALU_SUB   = 4'b0001;
  localparam logic [3:0] ALU_AND   = 4'b0010;
  localparam logic [3:0] ALU_OR    = 4'b0011;
  localparam logic [3:0] ALU_XOR   = 4'b0100;
  localparam logic [3:0] ALU_PASSB = 4'b1111;

endpackage

// File: rtl/ula_seq.sv
// Accumulator sequencer driving an external ALU: accepts load/ALU commands,
// runs one EXEC cycle per ALU command and holds the result until consumed.
module ula_seq
  import ula_pkg::*;
#(
  parameter int W  = ula_pkg::W,
  parameter int SW = ula_pkg::SW
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          cmd_valid,
  output logic          cmd_ready,
  input  logic [SW-1:0] cmd_op,
  input  logic [W-1:0]  cmd_b,
  input  logic          cmd_load,
  input  logic          cmd_wb,
  output logic [W-1:0]  alu_a,
  output logic [W-1:0]  alu_b,
  output logic [SW-1:0] alu_s,
  output logic          alu_r,
  input  logic [W-1:0]  alu_o,
  input  logic          alu_cout,
  input  logic          alu_zero,
  output logic          res_valid,
  input  logic          res_ready,
  output logic [W-1:0]  res_data,
  output logic          res_cout,
  output logic          res_zero,
  output logic [W-1:0]  acc
);

  state_t        state;
  state_t        state_nx;
  logic [SW-1:0] op_reg;
  logic [W-1:0]  b_reg;
  logic          wb_reg;
  logic          accept;

  assign accept = cmd_valid && (state == IDLE);

  // ALU operands come straight from registers so no cmd_* path reaches them
  assign alu_a = acc;
  assign alu_b = b_reg;
  assign alu_s = op_reg;

  // Next-state decode
  always_comb begin
    state_nx = state;
    case (state)
      IDLE: begin
        if (cmd_valid) begin
          state_nx = cmd_load ? RESP : EXEC;
        end else begin
          state_nx = IDLE;
        end
      end
      EXEC: state_nx = RESP;
      RESP: begin
        if (res_ready) begin
          state_nx = IDLE;
        end else begin
          state_nx = RESP;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  // State, datapath registers and registered handshake flags
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      acc       <= '0;
      op_reg    <= '0;
      b_reg     <= '0;
      wb_reg    <= 1'b0;
      res_data  <= '0;
      res_cout  <= 1'b0;
      res_zero  <= 1'b0;
      alu_r     <= 1'b0;
      res_valid <= 1'b0;
      cmd_ready <= 1'b1;
    end else begin
      state     <= state_nx;
      alu_r     <= (state_nx == EXEC);
      res_valid <= (state_nx == RESP);
      cmd_ready <= (state_nx == IDLE);
      case (state)
        IDLE: begin
          if (accept) begin
            op_reg <= cmd_op;
            b_reg  <= cmd_b;
            wb_reg <= cmd_wb;
            if (cmd_load) begin
              acc      <= cmd_b;
              res_data <= cmd_b;
              res_cout <= 1'b0;
              res_zero <= (cmd_b == '0);
            end
          end
        end
        EXEC: begin
          // Flags are taken as reported by the ALU, never recomputed here
          res_data <= alu_o;
          res_cout <= alu_cout;
          res_zero <= alu_zero;
          if (wb_reg) begin
            acc <= alu_o;
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ula_seq.sv
// Self-checking bench for ula_seq with a behavioural ALU on the alu_* ports.
module tb_ula_seq;
  import ula_pkg::*;

  localparam int TW = 5;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          cmd_valid = 1'b0;
  logic          cmd_ready;
  logic [3:0]    cmd_op = 4'd0;
  logic [TW-1:0] cmd_b = 5'd0;
  logic          cmd_load = 1'b0;
  logic          cmd_wb = 1'b0;
  logic [TW-1:0] alu_a, alu_b, alu_o;
  logic [3:0]    alu_s;
  logic          alu_r, alu_cout, alu_zero;
  logic          res_valid;
  logic          res_ready = 1'b1;
  logic [TW-1:0] res_data, acc;
  logic          res_cout, res_zero;

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct {
    logic [TW-1:0] data;
    logic          cout;
    logic          zero;
    logic [TW-1:0] acc;
  } exp_t;

  typedef struct {
    logic          ld;
    logic [3:0]    op;
    logic [TW-1:0] b;
    logic          wb;
    exp_t          e;
  } vec_t;

  exp_t sb[$];
  vec_t vecs[12];

  always #5 clk = ~clk;

  ula_seq #(.W(TW), .SW(4)) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
    .cmd_b(cmd_b), .cmd_load(cmd_load), .cmd_wb(cmd_wb),
    .alu_a(alu_a), .alu_b(alu_b), .alu_s(alu_s), .alu_r(alu_r),
    .alu_o(alu_o), .alu_cout(alu_cout), .alu_zero(alu_zero),
    .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data),
    .res_cout(res_cout), .res_zero(res_zero), .acc(acc)
  );

  // Behavioural team ALU; cout on SUB is the borrow out
  always_comb begin
    logic [TW:0] t;
    t = '0;
    case (alu_s)
      ALU_ADD:   t = {1'b0, alu_a} + {1'b0, alu_b};
      ALU_SUB:   t = {1'b0, alu_a} - {1'b0, alu_b};
      ALU_AND:   t = {1'b0, alu_a & alu_b};
      ALU_OR:    t = {1'b0, alu_a | alu_b};
      ALU_XOR:   t = {1'b0, alu_a ^ alu_b};
      ALU_PASSB: t = {1'b0, alu_b};
      default:   t = '0;
    endcase
    alu_o    = t[TW-1:0];
    alu_cout = t[TW];
    alu_zero = (t[TW-1:0] == 5'd0);
  end

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Scoreboard: compare each result at the cycle it is handed over
  always @(negedge clk) begin
    if (!rst && res_valid && res_ready) begin
      if (sb.size() == 0) begin
        check("unexpected_result", 1, 0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("res_data", int'(res_data), int'(e.data));
        check("res_cout", int'(res_cout), int'(e.cout));
        check("res_zero", int'(res_zero), int'(e.zero));
        check("acc", int'(acc), int'(e.acc));
      end
    end
  end

  task automatic wait_ready();
    int t = 0;
    @(negedge clk);
    while (!cmd_ready && t < 20) begin
      @(negedge clk);
      t++;
    end
    if (!cmd_ready) check("cmd_ready_timeout", 0, 1);
  endtask

  task automatic send(input vec_t v);
    wait_ready();
    cmd_valid = 1'b1;
    cmd_load  = v.ld;
    cmd_op    = v.op;
    cmd_b     = v.b;
    cmd_wb    = v.wb;
    sb.push_back(v.e);
    @(posedge clk);
    #1 cmd_valid = 1'b0;
    @(negedge clk);
    check("valid_after_1", int'(res_valid), int'(v.ld));
    check("alu_r_phase", int'(alu_r), int'(!v.ld));
    if (!v.ld) begin
      check("alu_s", int'(alu_s), int'(v.op));
      @(negedge clk);
      check("valid_after_2", int'(res_valid), 1);
      check("alu_r_off", int'(alu_r), 0);
    end
  endtask

  function automatic vec_t mk(input logic ld, input logic [3:0] op, input int b,
                              input logic wb, input int d, input logic c,
                              input logic z, input int a);
    vec_t v;
    v.ld = ld; v.op = op; v.b = TW'(b); v.wb = wb;
    v.e.data = TW'(d); v.e.cout = c; v.e.zero = z; v.e.acc = TW'(a);
    return v;
  endfunction

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0]  = mk(1'b1, ALU_ADD,   20, 1'b0, 20, 1'b0, 1'b0, 20);
    vecs[1]  = mk(1'b0, ALU_ADD,   15, 1'b1,  3, 1'b1, 1'b0,  3);
    vecs[2]  = mk(1'b1, ALU_ADD,    7, 1'b0,  7, 1'b0, 1'b0,  7);
    vecs[3]  = mk(1'b0, ALU_SUB,    7, 1'b0,  0, 1'b0, 1'b1,  7);
    vecs[4]  = mk(1'b0, ALU_SUB,    9, 1'b1, 30, 1'b1, 1'b0, 30);
    vecs[5]  = mk(1'b0, ALU_PASSB,  5, 1'b1,  5, 1'b0, 1'b0,  5);
    vecs[6]  = mk(1'b0, ALU_AND,    3, 1'b1,  1, 1'b0, 1'b0,  1);
    vecs[7]  = mk(1'b0, ALU_OR,    12, 1'b1, 13, 1'b0, 1'b0, 13);
    vecs[8]  = mk(1'b0, ALU_XOR,   13, 1'b0,  0, 1'b0, 1'b1, 13);
    vecs[9]  = mk(1'b1, ALU_SUB,    0, 1'b1,  0, 1'b0, 1'b1,  0);
    vecs[10] = mk(1'b0, ALU_ADD,   31, 1'b1, 31, 1'b0, 1'b0, 31);
    vecs[11] = mk(1'b0, ALU_ADD,    1, 1'b1,  0, 1'b1, 1'b1,  0);

    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("rst_cmd_ready", int'(cmd_ready), 1);
    check("rst_res_valid", int'(res_valid), 0);
    check("rst_acc", int'(acc), 0);
    check("rst_alu_r", int'(alu_r), 0);
    check("rst_res_data", int'(res_data), 0);
    check("rst_res_flags", int'({res_cout, res_zero}), 0);

    for (int i = 0; i < 12; i++) send(vecs[i]);

    // Consumer stalls for 5 cycles while a new command waits
    @(posedge clk);
    #1 res_ready = 1'b0;
    send(mk(1'b1, ALU_ADD, 11, 1'b0, 11, 1'b0, 1'b0, 11));
    cmd_valid = 1'b1; cmd_load = 1'b1; cmd_b = 5'd3;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("hold_valid", int'(res_valid), 1);
      check("hold_data", int'(res_data), 11);
      check("hold_cmd_ready", int'(cmd_ready), 0);
      check("hold_acc", int'(acc), 11);
    end
    @(posedge clk);
    #1 begin cmd_valid = 1'b0; res_ready = 1'b1; end
    @(negedge clk);
    @(negedge clk);
    check("release_cmd_ready", int'(cmd_ready), 1);
    check("release_valid", int'(res_valid), 0);
    check("release_acc", int'(acc), 11);

    // Reset during EXEC aborts the ALU command
    send(mk(1'b1, ALU_ADD, 9, 1'b0, 9, 1'b0, 1'b0, 9));
    wait_ready();
    cmd_valid = 1'b1; cmd_load = 1'b0; cmd_op = ALU_ADD; cmd_b = 5'd1; cmd_wb = 1'b1;
    @(posedge clk);
    #1 begin cmd_valid = 1'b0; rst = 1'b1; end
    @(negedge clk);
    check("exec_alu_r", int'(alu_r), 1);
    check("exec_alu_a", int'(alu_a), 9);
    check("exec_alu_b", int'(alu_b), 1);
    @(negedge clk);
    check("abort_acc", int'(acc), 0);
    check("abort_valid", int'(res_valid), 0);
    check("abort_cmd_ready", int'(cmd_ready), 1);
    check("abort_alu_r", int'(alu_r), 0);
    @(posedge clk);
    #1 rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("abort_no_valid", int'(res_valid), 0);
    end

    check("scoreboard_empty", sb.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
